// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier blocks:
// controller state encoding and shift direction.
package mult_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        TEST  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } ctrl_state_t;

    localparam logic SHIFT_RIGHT = 1'b1;

endpackage

// File: rtl/step_counter.sv
// Iteration down-counter for the shift-add controller.
// Priority is clear, then load, then decrement. The counter saturates at zero.
module step_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          is_one
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign is_one = (cnt == CW'(1));

endmodule

// File: rtl/shift_add_ctrl.sv
// Moore sequencing controller for the unsigned shift-and-add multiplier.
// Drives the A/Q/M register strobes through WIDTH test/shift iterations.
module shift_add_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          q0,
    output logic          busy,
    output logic          done,
    output logic          load_m,
    output logic          load_q,
    output logic          clr_a,
    output logic          add_en,
    output logic          shift_en,
    output logic          shift_dir,
    output logic [CW-1:0] step_cnt
);

    ctrl_state_t state;
    ctrl_state_t state_nxt;
    logic        abort_hit;
    logic        cnt_is_one;

    assign abort_hit = abort && (state != IDLE);

    always_comb begin
        state_nxt = state;
        if (abort_hit) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = LOAD;
                LOAD:    state_nxt = TEST;
                TEST:    state_nxt = SHIFT;
                SHIFT:   state_nxt = cnt_is_one ? DONE : TEST;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter is loaded on the edge leaving LOAD, so TEST always sees WIDTH first.
    step_counter #(
        .CW (CW)
    ) u_step_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (abort_hit),
        .load     (state == LOAD),
        .load_val (CW'(WIDTH)),
        .dec      (state == SHIFT),
        .cnt      (step_cnt),
        .is_one   (cnt_is_one)
    );

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign load_m    = (state == LOAD);
    assign load_q    = (state == LOAD);
    assign clr_a     = (state == LOAD);
    assign add_en    = (state == TEST) && q0;
    assign shift_en  = (state == SHIFT);
    assign shift_dir = shift_en ? SHIFT_RIGHT : 1'b0;

endmodule

// File: tb/tb_shift_add_ctrl.sv
// Scoreboard bench for shift_add_ctrl at WIDTH=4 and WIDTH=8, each driving
// a small A/Q/M/C datapath model whose product is compared against m*q.
module tb_shift_add_ctrl;

    typedef struct {
        logic [15:0] prod;
        int          adds;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- WIDTH=4 instance ----------------
    logic       start4 = 1'b0, abort4 = 1'b0, q0_4;
    logic       busy4, done4, load_m4, load_q4, clr_a4, add4, shift4, dir4;
    logic [2:0] step4;
    logic [3:0] mop4 = '0, qop4 = '0, m4r, q4r, a4r;
    logic       c4r;
    exp_t       sb4[$];

    shift_add_ctrl #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .q0(q0_4),
        .busy(busy4), .done(done4), .load_m(load_m4), .load_q(load_q4),
        .clr_a(clr_a4), .add_en(add4), .shift_en(shift4), .shift_dir(dir4),
        .step_cnt(step4)
    );

    assign q0_4 = q4r[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m4r <= '0; q4r <= '0; a4r <= '0; c4r <= 1'b0;
        end else begin
            if (load_m4) m4r <= mop4;
            if (load_q4) q4r <= qop4;
            if (clr_a4)      {c4r, a4r} <= '0;
            else if (add4)   {c4r, a4r} <= {1'b0, a4r} + {1'b0, m4r};
            else if (shift4) {c4r, a4r, q4r} <= {1'b0, c4r, a4r, q4r[3:1]};
        end
    end

    // ---------------- WIDTH=8 instance ----------------
    logic       start8 = 1'b0, abort8 = 1'b0, q0_8;
    logic       busy8, done8, load_m8, load_q8, clr_a8, add8, shift8, dir8;
    logic [3:0] step8;
    logic [7:0] mop8 = '0, qop8 = '0, m8r, q8r, a8r;
    logic       c8r;
    exp_t       sb8[$];

    shift_add_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8), .q0(q0_8),
        .busy(busy8), .done(done8), .load_m(load_m8), .load_q(load_q8),
        .clr_a(clr_a8), .add_en(add8), .shift_en(shift8), .shift_dir(dir8),
        .step_cnt(step8)
    );

    assign q0_8 = q8r[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m8r <= '0; q8r <= '0; a8r <= '0; c8r <= 1'b0;
        end else begin
            if (load_m8) m8r <= mop8;
            if (load_q8) q8r <= qop8;
            if (clr_a8)      {c8r, a8r} <= '0;
            else if (add8)   {c8r, a8r} <= {1'b0, a8r} + {1'b0, m8r};
            else if (shift8) {c8r, a8r, q8r} <= {1'b0, c8r, a8r, q8r[7:1]};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitors ----------------
    int load_cyc4 = 0, adds4 = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            if (load_m4) begin load_cyc4 = cyc; adds4 = 0; end
            if (add4) adds4++;
            chk("excl4", 32'($onehot0({load_m4, add4, shift4})), 1);
            chk("load_group4", 32'({load_q4, clr_a4}), 32'({load_m4, load_m4}));
            chk("dir4", 32'(dir4), 32'(shift4));
            chk("cnt_max4", 32'(step4 <= 3'd4), 1);
            if (done4) begin
                if (sb4.size() == 0) begin
                    chk("spurious_done4", 1, 0);
                end else begin
                    e = sb4.pop_front();
                    chk("product4", 32'({a4r, q4r}), 32'(e.prod));
                    chk("latency4", cyc - load_cyc4, 9);
                    chk("adds4", adds4, e.adds);
                end
            end
        end
    end

    int load_cyc8 = 0, adds8 = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            if (load_m8) begin load_cyc8 = cyc; adds8 = 0; end
            if (add8) adds8++;
            chk("excl8", 32'($onehot0({load_m8, add8, shift8})), 1);
            chk("load_group8", 32'({load_q8, clr_a8}), 32'({load_m8, load_m8}));
            chk("dir8", 32'(dir8), 32'(shift8));
            chk("cnt_max8", 32'(step8 <= 4'd8), 1);
            if (done8) begin
                if (sb8.size() == 0) begin
                    chk("spurious_done8", 1, 0);
                end else begin
                    e = sb8.pop_front();
                    chk("product8", 32'({a8r, q8r}), 32'(e.prod));
                    chk("latency8", cyc - load_cyc8, 17);
                    chk("adds8", adds8, e.adds);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue4(input logic [3:0] m, input logic [3:0] q, input bit push);
        @(negedge clk);
        mop4 = m; qop4 = q; start4 = 1'b1;
        if (push) sb4.push_back('{prod: 16'(m) * 16'(q), adds: $countones(q)});
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic issue8(input logic [7:0] m, input logic [7:0] q, input bit push);
        @(negedge clk);
        mop8 = m; qop8 = q; start8 = 1'b1;
        if (push) sb8.push_back('{prod: 16'(m) * 16'(q), adds: $countones(q)});
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic wait_idle4(input int bound);
        int n = 0;
        while (busy4 && n < bound) begin @(negedge clk); n++; end
        chk("timeout4", 32'(busy4), 0);
    endtask

    task automatic wait_idle8(input int bound);
        int n = 0;
        while (busy8 && n < bound) begin @(negedge clk); n++; end
        chk("timeout8", 32'(busy8), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        // Reset held with start asserted: nothing moves.
        start4 = 1'b1; start8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_outs4", 32'({busy4, done4, load_m4, load_q4, clr_a4, add4, shift4, dir4}), 0);
            chk("rst_cnt4", 32'(step4), 0);
            chk("rst_outs8", 32'({busy8, done8, load_m8, load_q8, clr_a8, add8, shift8, dir8}), 0);
            chk("rst_cnt8", 32'(step8), 0);
        end
        start4 = 1'b0; start8 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Directed WIDTH=4 timing with q0 sequence 1,0,1,1 (Q=13).
        issue4(4'd5, 4'd13, 1'b1);
        for (int k = 1; k <= 11; k++) begin
            chk($sformatf("add_c%0d", k), 32'(add4), 32'(k == 2 || k == 6 || k == 8));
            chk($sformatf("shift_c%0d", k), 32'(shift4), 32'(k >= 3 && k <= 9 && (k % 2 == 1)));
            chk($sformatf("done_c%0d", k), 32'(done4), 32'(k == 10));
            if (k == 2) chk("cnt_first_test4", 32'(step4), 4);
            @(negedge clk);
        end

        // 13 x 11 = 143
        issue4(4'd13, 4'd11, 1'b1);
        wait_idle4(40);

        // Abort in the second SHIFT cycle (cycle 5).
        issue4(4'd9, 4'd15, 1'b0);
        repeat (4) @(negedge clk);
        chk("abort_in_shift", 32'(shift4), 1);
        chk("abort_cnt_before", 32'(step4), 3);
        abort4 = 1'b1;
        @(negedge clk);
        abort4 = 1'b0;
        chk("abort_idle", 32'(busy4), 0);
        chk("abort_cnt", 32'(step4), 0);
        begin
            int saw_done = 0;
            for (int i = 0; i < 12; i++) begin
                if (done4) saw_done++;
                @(negedge clk);
            end
            chk("abort_no_done", saw_done, 0);
        end
        issue4(4'd7, 4'd6, 1'b1);
        wait_idle4(40);

        // Abort with simultaneous start while IDLE: start wins.
        @(negedge clk);
        abort4 = 1'b1;
        issue4(4'd3, 4'd9, 1'b1);
        abort4 = 1'b0;
        chk("start_over_abort", 32'(load_m4), 1);
        wait_idle4(40);

        // start held continuously: LOAD every 2*W+3 cycles, no extra LOAD.
        @(negedge clk);
        mop4 = 4'($urandom); qop4 = 4'($urandom);
        for (int i = 0; i < 3; i++)
            sb4.push_back('{prod: 16'(mop4) * 16'(qop4), adds: $countones(qop4)});
        start4 = 1'b1;
        @(negedge clk);
        for (int off = 0; off <= 32; off++) begin
            chk($sformatf("held_load_o%0d", off), 32'(load_m4), 32'(off % 11 == 0 && off <= 22));
            if (off == 23) start4 = 1'b0;
            @(negedge clk);
        end
        wait_idle4(40);

        // WIDTH=8, 255 x 255.
        issue8(8'd255, 8'd255, 1'b1);
        wait_idle8(60);

        // Asynchronous reset mid-operation takes effect without a clock edge.
        issue8(8'($urandom), 8'($urandom), 1'b1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy8), 0);
        chk("async_rst_cnt", 32'(step8), 0);
        chk("async_rst_strb", 32'({done8, load_m8, add8, shift8}), 0);
        sb8.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised operands on both widths.
        for (int i = 0; i < 12; i++) begin
            issue4(4'($urandom), 4'($urandom), 1'b1);
            wait_idle4(40);
            issue8(8'($urandom), 8'($urandom), 1'b1);
            wait_idle8(60);
        end

        repeat (3) @(negedge clk);
        chk("sb4_drained", sb4.size(), 0);
        chk("sb8_drained", sb8.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_add_ctrl.md
# shift_add_ctrl

Sequencing controller for the unsigned shift-and-add multiplier. It accepts a start request, then drives the load, add and shift enables of the accumulator (A), multiplier (Q) and multiplicand (M) shift registers through WIDTH add/shift iterations. It raises a one-cycle done pulse when the product in {C, A, Q} is final. It sits directly upstream of the datapath registers and drives their load_en, shift_en and shift_dir pins.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; must be ≥ 2.
- CW, $clog2(WIDTH+1), derived width of the iteration counter; not to be overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  request a new multiplication; honoured only in IDLE.
- abort  in  1  cancel the operation in progress; ignored in IDLE.
- q0  in  1  current Q[0] from the multiplier register.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; the product is valid while it is high.
- load_m  out  1  load enable to the M register.
- load_q  out  1  load enable to the Q register.
- clr_a  out  1  clears A and the carry flip-flop C.
- add_en  out  1  loads A with A+M, with the carry-out going to C.
- shift_en  out  1  shift enable to both the A and Q registers.
- shift_dir  out  1  equals 1 (right shift) when shift_en is high, otherwise 0.
- step_cnt  out  CW  number of iterations remaining.

## Operation
- Moore FSM with states IDLE, LOAD, TEST, SHIFT, DONE. All outputs are decoded from the registered state and the counter; q0 gates add_en only.
- IDLE: all strobes are low. start=1 moves the FSM to LOAD.
- LOAD: load_m, load_q and clr_a are high. step_cnt is set to WIDTH. Next state is TEST.
- TEST: add_en = q0. Next state is SHIFT.
- SHIFT: shift_en=1 and shift_dir=1. step_cnt decrements. If step_cnt was 1 before the decrement, next state is DONE; otherwise it is TEST.
- DONE: done=1. Next state is IDLE. step_cnt stays at 0.
- abort=1 in LOAD, TEST, SHIFT or DONE: next state is IDLE. No done pulse is issued, and step_cnt is cleared to 0. abort has priority over all other transitions.
- start outside IDLE is ignored; there is no queuing.
- Simultaneous start and abort in IDLE: the start is honoured.
- The strobes load_*, add_en and shift_en are mutually exclusive in every state, except that load_m, load_q and clr_a are asserted together in LOAD.
- Width rule: step_cnt never exceeds WIDTH and never wraps below 0.

## Timing
- Reset values: state=IDLE, step_cnt=0, and every output is 0.
- Reset mid-operation forces the reset values immediately, without waiting for a clock edge.
- start sampled high at edge 0 produces this sequence:
  - cycle 1 is LOAD;
  - TEST occupies the even cycles 2…2·WIDTH;
  - SHIFT occupies the odd cycles 3…2·WIDTH+1;
  - cycle 2·WIDTH+2 is DONE;
  - cycle 2·WIDTH+3 is IDLE.
- Total latency from start to done is 2·WIDTH+2 cycles.
- Back-to-back operation: the earliest accepted restart is a start sampled at the edge ending the first IDLE cycle after DONE.
- q0 is sampled combinationally during TEST. The datapath must present Q[0] as it stands after the previous SHIFT.

## Structure
- Shared package mult_pkg holds:
  - typedef enum logic [2:0] ctrl_state_t {IDLE, LOAD, TEST, SHIFT, DONE};
  - the SHIFT_RIGHT = 1'b1 constant used by all multiplier blocks.
- One sub-module, step_counter (parameter CW). It is a synchronous down-counter with load, decrement and clear inputs, plus an is_one flag.
- The FSM and output decode live in shift_add_ctrl itself.

## Test plan
- Reset with start=1 held: busy=0, done=0, step_cnt=0 and all strobes 0; no transition occurs until rst_n rises.
- WIDTH=4, start pulse, q0 driven 1,0,1,1 in successive TEST cycles:
  - add_en is high in cycles 2, 6 and 8;
  - shift_en is high in cycles 3, 5, 7 and 9;
  - done is high in cycle 10 only.
- WIDTH=4 with the bench datapath model, operands M=13 and Q=11: {A,Q}=143 when done is high.
- abort asserted in the second SHIFT cycle: IDLE the following cycle, done never pulses, step_cnt=0; a fresh start then runs a complete 10-cycle sequence.
- start held high continuously: operations repeat with exactly one IDLE cycle between DONE and the next LOAD; starts asserted while busy produce no extra LOAD.
- WIDTH=8, operands 255×255 (q0 always 1): eight add_en pulses, done at cycle 18, product 65025.
